// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller.
package hazard_pkg;

    // Pipeline register indices
    localparam int unsigned STG_PC       = 0;
    localparam int unsigned STG_IF_ID    = 1;
    localparam int unsigned STG_ID_EX    = 2;
    localparam int unsigned STG_EX_MEMWB = 3;

    // Load-use bubble counter width and its value type
    localparam int unsigned LU_CNT_W = 4;
    typedef logic [LU_CNT_W-1:0] lu_cnt_t;

    // Default stall watchdog threshold in cycles
    localparam int unsigned TIMEOUT_DEF = 1024;

endpackage

// File: rtl/hazard_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// o_sat_nxt_c flags that the count will sit at MAX after the coming edge.
module hazard_sat_cnt #(
    parameter  int unsigned MAX = 16,
    localparam int unsigned W   = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_sat_nxt_c
);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_cnt_nxt;

    // Next count: clear wins, otherwise increment until MAX
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_cnt_nxt = '0;
        end else if (i_inc && (r_cnt != W'(MAX))) begin
            w_cnt_nxt = r_cnt + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_sat_nxt_c = (w_cnt_nxt == W'(MAX));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: per-register hold and bubble enables,
// pending redirect across stalls, multi-cycle load-use bubbles and a
// sticky stall watchdog.
// Optional build macro HAZARD_PERF_CNT_EN adds stall/bubble cycle counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned STAGES    = STG_EX_MEMWB + 1,
    parameter int unsigned LU_STAGE  = STG_ID_EX,
    parameter int unsigned LU_CYCLES = 1,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
    parameter int unsigned PERF_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stall_req,
    input  logic [STAGES-1:0] flush_req,
    input  logic              redirect,
    input  logic              load_use,
    output logic [STAGES-1:0] stall,
    output logic [STAGES-1:0] flush,
    output logic              lu_active,
    output logic              stall_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cycles,
    output logic [PERF_W-1:0] perf_bubble_cycles
`endif
);

    logic [STAGES-1:0] w_stall;
    logic [STAGES-1:0] w_flush;
    logic [STAGES-1:0] w_redir_f;
    logic              w_req_acc;
    logic              w_hold_lu;
    lu_cnt_t           r_lu_cnt;
    lu_cnt_t           w_lu_cnt_nxt;
    logic              r_pend_redir;
    logic              w_pend_redir_nxt;
    logic              r_timeout;
    logic              w_sat_nxt;

    // Stall: any downstream request holds everything upstream; a live
    // load-use count holds the registers feeding the bubble stage
    always_comb begin
        w_hold_lu = (r_lu_cnt != '0);
        w_req_acc = 1'b0;
        w_stall   = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_req_acc  = w_req_acc | stall_req[i];
            w_stall[i] = w_req_acc | (w_hold_lu & (i < int'(LU_STAGE)));
        end
    end

    // Bubble insertion: a held register never flushes; bit 0 has no bubble
    always_comb begin
        w_redir_f            = '0;
        w_redir_f[STG_IF_ID] = redirect | r_pend_redir;
        w_flush              = '0;
        for (int i = 1; i < int'(STAGES); i++) begin
            w_flush[i] = ~w_stall[i] & (w_stall[i-1] | flush_req[i] | w_redir_f[i]);
        end
    end

    // Redirect that hits a stalled IF/ID waits until the bubble is taken
    always_comb begin
        w_pend_redir_nxt = (r_pend_redir | (redirect & w_stall[STG_IF_ID]))
                         & ~w_flush[STG_IF_ID];
    end

    // Load-use counter: reload on every event, drain only while the
    // bubble stage is free to accept a bubble
    always_comb begin
        w_lu_cnt_nxt = r_lu_cnt;
        if (load_use) begin
            w_lu_cnt_nxt = LU_CNT_W'(LU_CYCLES);
        end else if (w_hold_lu && !w_stall[LU_STAGE]) begin
            w_lu_cnt_nxt = r_lu_cnt - LU_CNT_W'(1);
        end
    end

    // Watchdog: consecutive PC stall cycles, saturating at TIMEOUT
    hazard_sat_cnt #(
        .MAX (TIMEOUT)
    ) u_wdog (
        .clk         (clk),
        .rst         (rst),
        .i_inc       (w_stall[STG_PC]),
        .i_clr       (~w_stall[STG_PC]),
        .o_sat_nxt_c (w_sat_nxt)
    );

    // Controller state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lu_cnt     <= '0;
            r_pend_redir <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_lu_cnt     <= w_lu_cnt_nxt;
            r_pend_redir <= w_pend_redir_nxt;
            r_timeout    <= r_timeout | w_sat_nxt;
        end
    end

    // Hold/bubble outputs are forced low while reset is asserted
    assign stall         = rst ? '0 : w_stall;
    assign flush         = rst ? '0 : w_flush;
    assign lu_active     = ~rst & w_hold_lu;
    assign stall_timeout = r_timeout;

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] r_perf_stall;
    logic [PERF_W-1:0] r_perf_bubble;

    // Free-running wrap-around counters of stall and bubble cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall  <= '0;
            r_perf_bubble <= '0;
        end else begin
            if (w_stall[STG_PC]) begin
                r_perf_stall <= r_perf_stall + PERF_W'(1);
            end
            if (|w_flush[STAGES-1:1]) begin
                r_perf_bubble <= r_perf_bubble + PERF_W'(1);
            end
        end
    end

    assign perf_stall_cycles  = r_perf_stall;
    assign perf_bubble_cycles = r_perf_bubble;
`else
    // Build without performance counters: no extra ports or state
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl (TIMEOUT=16). A second instance
// with LU_CYCLES=3 shares the inputs for the multi-cycle bubble cases.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] stall_req;
    logic [3:0] flush_req;
    logic       redirect;
    logic       load_use;

    logic [3:0] stall,  stall3;
    logic [3:0] flush,  flush3;
    logic       lu_active, lu_active3;
    logic       stall_timeout, stall_timeout3;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cycles,  perf_stall_cycles3;
    logic [31:0] perf_bubble_cycles, perf_bubble_cycles3;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(
        .STAGES    (4),
        .LU_STAGE  (2),
        .LU_CYCLES (1),
        .TIMEOUT   (16),
        .PERF_W    (32)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .stall_req     (stall_req),
        .flush_req     (flush_req),
        .redirect      (redirect),
        .load_use      (load_use),
        .stall         (stall),
        .flush         (flush),
        .lu_active     (lu_active),
        .stall_timeout (stall_timeout)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_stall_cycles  (perf_stall_cycles),
        .perf_bubble_cycles (perf_bubble_cycles)
`endif
    );

    hazard_ctrl #(
        .STAGES    (4),
        .LU_STAGE  (2),
        .LU_CYCLES (3),
        .TIMEOUT   (16),
        .PERF_W    (32)
    ) u_dut3 (
        .clk           (clk),
        .rst           (rst),
        .stall_req     (stall_req),
        .flush_req     (flush_req),
        .redirect      (redirect),
        .load_use      (load_use),
        .stall         (stall3),
        .flush         (flush3),
        .lu_active     (lu_active3),
        .stall_timeout (stall_timeout3)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_stall_cycles  (perf_stall_cycles3),
        .perf_bubble_cycles (perf_bubble_cycles3)
`endif
    );

    typedef struct {
        string      tag;
        logic [3:0] st;
        logic [3:0] fl;
        logic       la;
        logic       to;
        bit         dut3;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic push_exp(input string tag, input logic [3:0] st, input logic [3:0] fl,
                            input logic la, input logic to, input bit d3);
        exp_t e;
        e.tag  = tag;
        e.st   = st;
        e.fl   = fl;
        e.la   = la;
        e.to   = to;
        e.dut3 = d3;
        sb_q.push_back(e);
    endtask

    task automatic check_all();
        exp_t       e;
        logic [3:0] ost, ofl;
        logic       ola, oto;
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            if (e.dut3) begin
                ost = stall3; ofl = flush3; ola = lu_active3; oto = stall_timeout3;
            end else begin
                ost = stall;  ofl = flush;  ola = lu_active;  oto = stall_timeout;
            end
            n_tests++;
            assert (ost === e.st) else begin
                n_fail++;
                $error("FAIL %s stall observed=%b expected=%b", e.tag, ost, e.st);
            end
            n_tests++;
            assert (ofl === e.fl) else begin
                n_fail++;
                $error("FAIL %s flush observed=%b expected=%b", e.tag, ofl, e.fl);
            end
            n_tests++;
            assert (ola === e.la) else begin
                n_fail++;
                $error("FAIL %s lu_active observed=%b expected=%b", e.tag, ola, e.la);
            end
            n_tests++;
            assert (oto === e.to) else begin
                n_fail++;
                $error("FAIL %s stall_timeout observed=%b expected=%b", e.tag, oto, e.to);
            end
        end
    endtask

    // One cycle: drive at the falling edge, compare 1 ns later
    task automatic step_x(input logic r, input logic [3:0] sr, input logic [3:0] fr,
                          input logic rd, input logic lu, input string tag,
                          input logic [3:0] est, input logic [3:0] efl, input logic ela,
                          input logic eto, input bit c3, input logic [3:0] est3,
                          input logic [3:0] efl3, input logic ela3);
        @(negedge clk);
        rst       = r;
        stall_req = sr;
        flush_req = fr;
        redirect  = rd;
        load_use  = lu;
        push_exp(tag, est, efl, ela, eto, 1'b0);
        if (c3) push_exp({tag, "_lu3"}, est3, efl3, ela3, eto, 1'b1);
        #1;
        check_all();
    endtask

    task automatic step(input logic r, input logic [3:0] sr, input logic [3:0] fr,
                        input logic rd, input logic lu, input string tag,
                        input logic [3:0] est, input logic [3:0] efl, input logic ela,
                        input logic eto);
        step_x(r, sr, fr, rd, lu, tag, est, efl, ela, eto, 1'b0, 4'b0, 4'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; stall_req = '0; flush_req = '0; redirect = 1'b0; load_use = 1'b0;
        @(posedge clk);

        // Reset gates everything even with every request active
        step(1, 4'b1111, 4'b1110, 1, 1, "rst_gate", 4'b0000, 4'b0000, 0, 0);
        step(1, 4'b0000, 4'b0000, 0, 0, "rst_hold", 4'b0000, 4'b0000, 0, 0);

        // Stall propagation and bubble below the stalled register
        step(0, 4'b1000, 4'b0000, 0, 0, "stall_ex",   4'b1111, 4'b0000, 0, 0);
        step(0, 4'b0010, 4'b0000, 0, 0, "stall_ifid", 4'b0011, 4'b0100, 0, 0);
        step(0, 4'b0000, 4'b0000, 0, 0, "idle0",      4'b0000, 4'b0000, 0, 0);

        // flush_req handling: accepted, ignored on stalled bit, bit 0 never flushes
        step(0, 4'b0000, 4'b1000, 0, 0, "freq_ok",      4'b0000, 4'b1000, 0, 0);
        step(0, 4'b0100, 4'b0100, 0, 0, "freq_stalled", 4'b0111, 4'b1000, 0, 0);
        step(0, 4'b0000, 4'b0001, 0, 0, "freq_bit0",    4'b0000, 4'b0000, 0, 0);
        step(0, 4'b1000, 4'b0010, 0, 0, "freq_all_st",  4'b1111, 4'b0000, 0, 0);
        step(0, 4'b0000, 4'b0000, 0, 0, "idle1",        4'b0000, 4'b0000, 0, 0);

        // Single load-use pulse (main: 1 bubble, second DUT: 3 bubbles)
        step_x(0, 4'b0000, 4'b0000, 0, 1, "lu_pulse", 4'b0000, 4'b0000, 0, 0, 1, 4'b0000, 4'b0000, 0);
        step_x(0, 4'b0000, 4'b0000, 0, 0, "lu_n1",    4'b0011, 4'b0100, 1, 0, 1, 4'b0011, 4'b0100, 1);
        step_x(0, 4'b0000, 4'b0000, 0, 0, "lu_n2",    4'b0000, 4'b0000, 0, 0, 1, 4'b0011, 4'b0100, 1);
        step_x(0, 4'b0000, 4'b0000, 0, 0, "lu_n3",    4'b0000, 4'b0000, 0, 0, 1, 4'b0011, 4'b0100, 1);
        step_x(0, 4'b0000, 4'b0000, 0, 0, "lu_n4",    4'b0000, 4'b0000, 0, 0, 1, 4'b0000, 4'b0000, 0);

        // Back-to-back load-use reloads the count rather than accumulating
        step_x(0, 4'b0000, 4'b0000, 0, 1, "lu_re_m0", 4'b0000, 4'b0000, 0, 0, 1, 4'b0000, 4'b0000, 0);
        step_x(0, 4'b0000, 4'b0000, 0, 1, "lu_re_m1", 4'b0011, 4'b0100, 1, 0, 1, 4'b0011, 4'b0100, 1);
        step_x(0, 4'b0000, 4'b0000, 0, 0, "lu_re_m2", 4'b0011, 4'b0100, 1, 0, 1, 4'b0011, 4'b0100, 1);
        step_x(0, 4'b0000, 4'b0000, 0, 0, "lu_re_m3", 4'b0000, 4'b0000, 0, 0, 1, 4'b0011, 4'b0100, 1);
        step_x(0, 4'b0000, 4'b0000, 0, 0, "lu_re_m4", 4'b0000, 4'b0000, 0, 0, 1, 4'b0011, 4'b0100, 1);
        step_x(0, 4'b0000, 4'b0000, 0, 0, "lu_re_m5", 4'b0000, 4'b0000, 0, 0, 1, 4'b0000, 4'b0000, 0);

        // Redirect during an IF/ID stall is deferred to the release cycle
        step(0, 4'b0010, 4'b0000, 1, 0, "redir_st1", 4'b0011, 4'b0100, 0, 0);
        step(0, 4'b0010, 4'b0000, 1, 0, "redir_st2", 4'b0011, 4'b0100, 0, 0);
        step(0, 4'b0010, 4'b0000, 0, 0, "redir_st3", 4'b0011, 4'b0100, 0, 0);
        step(0, 4'b0000, 4'b0000, 0, 0, "redir_rel", 4'b0000, 4'b0010, 0, 0);
        step(0, 4'b0000, 4'b0000, 0, 0, "redir_clr", 4'b0000, 4'b0000, 0, 0);
        step(0, 4'b0000, 4'b0000, 1, 0, "redir_now", 4'b0000, 4'b0010, 0, 0);
        step(0, 4'b0000, 4'b0000, 0, 0, "redir_one", 4'b0000, 4'b0000, 0, 0);

        // Downstream stall freezes the load-use count
        step(0, 4'b1000, 4'b0000, 0, 1, "lu_frz0", 4'b1111, 4'b0000, 0, 0);
        step(0, 4'b1000, 4'b0000, 0, 0, "lu_frz1", 4'b1111, 4'b0000, 1, 0);
        step(0, 4'b0000, 4'b0000, 0, 0, "lu_frz2", 4'b0011, 4'b0100, 1, 0);
        step(0, 4'b0000, 4'b0000, 0, 0, "lu_frz3", 4'b0000, 4'b0000, 0, 0);

        // Simultaneous redirect and load-use are both honoured
        step(0, 4'b0000, 4'b0000, 1, 1, "rd_lu0", 4'b0000, 4'b0010, 0, 0);
        step(0, 4'b0000, 4'b0000, 0, 0, "rd_lu1", 4'b0011, 4'b0100, 1, 0);
        step(0, 4'b0000, 4'b0000, 0, 0, "rd_lu2", 4'b0000, 4'b0000, 0, 0);

        // One cycle short of the watchdog threshold does not trip it
        for (int k = 0; k < 15; k++)
            step(0, 4'b0001, 4'b0000, 0, 0, "wdog15", 4'b0001, 4'b0010, 0, 0);
        step(0, 4'b0000, 4'b0000, 0, 0, "wdog15_rel", 4'b0000, 4'b0000, 0, 0);

        // Sixteen consecutive stall cycles trip the sticky flag
        for (int k = 0; k < 16; k++)
            step(0, 4'b0001, 4'b0000, 0, 0, "wdog16", 4'b0001, 4'b0010, 0, 0);
        step(0, 4'b0000, 4'b0000, 0, 0, "wdog_set",    4'b0000, 4'b0000, 0, 1);
        step(0, 4'b0000, 4'b0000, 0, 0, "wdog_sticky", 4'b0000, 4'b0000, 0, 1);

        // Reset mid-bubble with a pending redirect leaves nothing behind
        step(0, 4'b0010, 4'b0000, 1, 1, "rst_mid_pre", 4'b0011, 4'b0100, 0, 1);
        step(1, 4'b0000, 4'b0000, 0, 0, "rst_mid",     4'b0000, 4'b0000, 0, 1);
        step(0, 4'b0000, 4'b0000, 0, 0, "post_rst0",   4'b0000, 4'b0000, 0, 0);
        step(0, 4'b0000, 4'b0000, 0, 0, "post_rst1",   4'b0000, 4'b0000, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
